// File: rtl/request_distributor_if.sv
// Bundles the request_distributor issue-side and per-port consumer-side signals.
// master drives requests and consumer acks, slave is the distributor.
interface request_distributor_if #(
  parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
  parameter int NUM_REQUEST                  = 3,
  parameter int NUM_REQUEST_LOG2             = (NUM_REQUEST > 1) ? $clog2(NUM_REQUEST) : 1
);
  logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_in;
  logic [NUM_REQUEST_LOG2-1:0]                         request_dest_in;
  logic                                                request_critical_in;
  logic                                                request_valid_in;
  logic                                                issue_ack_out;
`ifdef REQUEST_DISTRIBUTOR_BROADCAST_EN
  logic                                                request_broadcast_in;
`endif
  logic [SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST-1:0] request_flatted_out;
  logic [NUM_REQUEST-1:0]                              request_critical_flatted_out;
  logic [NUM_REQUEST-1:0]                              request_valid_flatted_out;
  logic [NUM_REQUEST-1:0]                              issue_ack_flatted_in;
  logic [15:0]                                         drop_count_out;

  modport master (
`ifdef REQUEST_DISTRIBUTOR_BROADCAST_EN
    output request_broadcast_in,
`endif
    output request_in, request_dest_in, request_critical_in, request_valid_in,
    output issue_ack_flatted_in,
    input  issue_ack_out, request_flatted_out, request_critical_flatted_out,
    input  request_valid_flatted_out, drop_count_out
  );

  modport slave (
`ifdef REQUEST_DISTRIBUTOR_BROADCAST_EN
    input  request_broadcast_in,
`endif
    input  request_in, request_dest_in, request_critical_in, request_valid_in,
    input  issue_ack_flatted_in,
    output issue_ack_out, request_flatted_out, request_critical_flatted_out,
    output request_valid_flatted_out, drop_count_out
  );
endinterface

// File: rtl/request_distributor.sv
// Routes one request stream into per-port FIFOs (1-cycle push latency, per-port backpressure via full).
// Define REQUEST_DISTRIBUTOR_BROADCAST_EN to add request_broadcast_in (push into every port at once).
module request_distributor #(
  parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
  parameter int NUM_REQUEST                  = 3,
  parameter int OUTPUT_QUEUE_SIZE            = 2,
  parameter int NUM_REQUEST_LOG2             = (NUM_REQUEST > 1) ? $clog2(NUM_REQUEST) : 1
) (
  input logic                 clk_in,
  input logic                 reset_in,
  request_distributor_if.slave bus
);
  localparam int W  = SINGLE_REQUEST_WIDTH_IN_BITS;
  localparam int PW = $clog2(OUTPUT_QUEUE_SIZE);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]               QDEPTH      = CW'(OUTPUT_QUEUE_SIZE);
  localparam logic [NUM_REQUEST_LOG2:0]   NUM_REQ_EXT = (NUM_REQUEST_LOG2 + 1)'(NUM_REQUEST);

  logic [W:0]             mem    [NUM_REQUEST][OUTPUT_QUEUE_SIZE];
  logic [PW-1:0]          wr_ptr [NUM_REQUEST];
  logic [PW-1:0]          rd_ptr [NUM_REQUEST];
  logic [CW-1:0]          count  [NUM_REQUEST];
  logic [NUM_REQUEST-1:0] full, empty, push, pop;
  logic                   in_range, dest_full, broadcast, accept, ack, drop;

`ifdef REQUEST_DISTRIBUTOR_BROADCAST_EN
  assign broadcast = bus.request_broadcast_in;
`else
  assign broadcast = 1'b0;
`endif

  assign in_range = ({1'b0, bus.request_dest_in} < NUM_REQ_EXT);

  always_comb begin
    full  = '0;
    empty = '0;
    pop   = '0;
    for (int i = 0; i < NUM_REQUEST; i++) begin
      full[i]  = (count[i] == QDEPTH);
      empty[i] = (count[i] == '0);
      pop[i]   = ~empty[i] & bus.issue_ack_flatted_in[i];
    end
  end

  // Acceptance looks at the current count only; a same-cycle pop does not free a slot.
  always_comb begin
    dest_full = 1'b0;
    for (int i = 0; i < NUM_REQUEST; i++) begin
      if (bus.request_dest_in == NUM_REQUEST_LOG2'(i)) dest_full = full[i];
    end
  end

  always_comb begin
    if (broadcast)      accept = ~|full;
    else if (!in_range) accept = 1'b1;
    else                accept = ~dest_full;
  end

  assign ack               = ~reset_in & bus.request_valid_in & accept;
  assign bus.issue_ack_out = ack;
  assign drop              = ack & ~broadcast & ~in_range;

  always_comb begin
    push = '0;
    for (int i = 0; i < NUM_REQUEST; i++) begin
      push[i] = ack & (broadcast | (in_range & (bus.request_dest_in == NUM_REQUEST_LOG2'(i))));
    end
  end

  // Storage needs no reset: empty ports mask their head to zero.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_REQUEST; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {bus.request_critical_in, bus.request_in};
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUM_REQUEST; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      bus.drop_count_out <= '0;
    end else begin
      for (int i = 0; i < NUM_REQUEST; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
        else if (pop[i] && !push[i]) count[i] <= count[i] - CW'(1);
      end
      if (drop && (bus.drop_count_out != 16'hFFFF)) bus.drop_count_out <= bus.drop_count_out + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQUEST; g++) begin : g_port
    logic [W:0] head;
    assign head = mem[g][rd_ptr[g]];
    assign bus.request_flatted_out[g*W +: W]     = empty[g] ? '0 : head[W-1:0];
    assign bus.request_critical_flatted_out[g]   = ~empty[g] & head[W];
    assign bus.request_valid_flatted_out[g]      = ~empty[g];
  end
endmodule

// File: tb/tb_request_distributor.sv
// Directed self-checking bench for request_distributor (default 64-bit, 3 ports, depth 2).
module tb_request_distributor;
  localparam int W = 64;
  localparam int N = 3;

  logic clk_in = 1'b0;
  logic reset_in = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk_in = ~clk_in;

  request_distributor_if #(.SINGLE_REQUEST_WIDTH_IN_BITS(W), .NUM_REQUEST(N)) bus ();

  request_distributor #(
    .SINGLE_REQUEST_WIDTH_IN_BITS(W),
    .NUM_REQUEST(N),
    .OUTPUT_QUEUE_SIZE(2)
  ) dut (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.request_valid_in     = 1'b0;
    bus.request_dest_in      = '0;
    bus.request_in           = '0;
    bus.request_critical_in  = 1'b0;
    bus.issue_ack_flatted_in = '0;
`ifdef REQUEST_DISTRIBUTOR_BROADCAST_EN
    bus.request_broadcast_in = 1'b0;
`endif
  endtask

  task automatic send(input logic [1:0] dest, input logic [W-1:0] data, input logic crit);
    bus.request_valid_in    = 1'b1;
    bus.request_dest_in     = dest;
    bus.request_in          = data;
    bus.request_critical_in = crit;
  endtask

  task automatic test_reset();
    send(2'd1, 64'hDEAD, 1'b1);
    #1;
    vectors++;
    if (bus.issue_ack_out !== 1'b0) begin
      miscompares++; $display("FAIL reset_ack: got %b want 0", bus.issue_ack_out);
    end
    vectors++;
    if (bus.request_valid_flatted_out !== 3'b000) begin
      miscompares++; $display("FAIL reset_valid: got %b want 000", bus.request_valid_flatted_out);
    end
    vectors++;
    if (bus.request_flatted_out !== '0 || bus.request_critical_flatted_out !== 3'b000) begin
      miscompares++; $display("FAIL reset_data: got %h/%b want 0/000", bus.request_flatted_out, bus.request_critical_flatted_out);
    end
    vectors++;
    if (bus.drop_count_out !== 16'd0) begin
      miscompares++; $display("FAIL reset_drop: got %0d want 0", bus.drop_count_out);
    end
    @(negedge clk_in);
    reset_in = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_unicast();
    send(2'd1, 64'hA5, 1'b0);
    #1;
    vectors++;
    if (bus.issue_ack_out !== 1'b1) begin
      miscompares++; $display("FAIL uni_ack: got %b want 1", bus.issue_ack_out);
    end
    tick();
    idle();
    vectors++;
    if (bus.request_valid_flatted_out !== 3'b010) begin
      miscompares++; $display("FAIL uni_valid: got %b want 010", bus.request_valid_flatted_out);
    end
    vectors++;
    if (bus.request_flatted_out[1*W +: W] !== 64'hA5 || bus.request_critical_flatted_out !== 3'b000) begin
      miscompares++; $display("FAIL uni_head: got %h crit %b want a5 crit 000", bus.request_flatted_out[1*W +: W], bus.request_critical_flatted_out);
    end
    bus.issue_ack_flatted_in = 3'b010;
    tick();
    idle();
    vectors++;
    if (bus.request_valid_flatted_out !== 3'b000) begin
      miscompares++; $display("FAIL uni_drain: got %b want 000", bus.request_valid_flatted_out);
    end
  endtask

  task automatic test_full();
    send(2'd0, 64'h1, 1'b0);
    tick();
    send(2'd0, 64'h2, 1'b1);
    tick();
    send(2'd0, 64'h3, 1'b0);
    #1;
    vectors++;
    if (bus.issue_ack_out !== 1'b0) begin
      miscompares++; $display("FAIL full_reject: got %b want 0", bus.issue_ack_out);
    end
    bus.request_dest_in = 2'd2;
    #1;
    vectors++;
    if (bus.issue_ack_out !== 1'b1) begin
      miscompares++; $display("FAIL full_other_port: got %b want 1", bus.issue_ack_out);
    end
    tick();
    idle();
    vectors++;
    if (bus.request_valid_flatted_out !== 3'b101 || bus.request_flatted_out[0 +: W] !== 64'h1) begin
      miscompares++; $display("FAIL full_head0: got v=%b d=%h want v=101 d=1", bus.request_valid_flatted_out, bus.request_flatted_out[0 +: W]);
    end
    bus.issue_ack_flatted_in = 3'b101;
    tick();
    idle();
    vectors++;
    if (bus.request_valid_flatted_out !== 3'b001 || bus.request_flatted_out[0 +: W] !== 64'h2
        || bus.request_critical_flatted_out !== 3'b001) begin
      miscompares++; $display("FAIL full_head1: got v=%b d=%h c=%b want v=001 d=2 c=001", bus.request_valid_flatted_out, bus.request_flatted_out[0 +: W], bus.request_critical_flatted_out);
    end
    bus.issue_ack_flatted_in = 3'b001;
    tick();
    idle();
    vectors++;
    if (bus.request_valid_flatted_out !== 3'b000 || bus.request_flatted_out !== '0) begin
      miscompares++; $display("FAIL full_empty: got v=%b want 000 and zero payload", bus.request_valid_flatted_out);
    end
  endtask

  task automatic test_pop_while_full();
    send(2'd0, 64'h3, 1'b0);
    tick();
    send(2'd0, 64'h4, 1'b0);
    tick();
    send(2'd0, 64'h5, 1'b0);
    bus.issue_ack_flatted_in = 3'b001;
    #1;
    vectors++;
    if (bus.issue_ack_out !== 1'b0) begin
      miscompares++; $display("FAIL popfull_reject: got %b want 0", bus.issue_ack_out);
    end
    tick();
    bus.issue_ack_flatted_in = 3'b000;
    #1;
    vectors++;
    if (bus.issue_ack_out !== 1'b1 || bus.request_flatted_out[0 +: W] !== 64'h4) begin
      miscompares++; $display("FAIL popfull_retry: got ack=%b head=%h want ack=1 head=4", bus.issue_ack_out, bus.request_flatted_out[0 +: W]);
    end
    tick();
    idle();
    bus.issue_ack_flatted_in = 3'b001;
    tick();
    idle();
    vectors++;
    if (bus.request_flatted_out[0 +: W] !== 64'h5 || bus.request_valid_flatted_out !== 3'b001) begin
      miscompares++; $display("FAIL popfull_order: got head=%h v=%b want 5 001", bus.request_flatted_out[0 +: W], bus.request_valid_flatted_out);
    end
    bus.issue_ack_flatted_in = 3'b001;
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    send(2'd1, 64'h6, 1'b0);
    tick();
    send(2'd1, 64'h7, 1'b1);
    bus.issue_ack_flatted_in = 3'b010;
    #1;
    vectors++;
    if (bus.issue_ack_out !== 1'b1) begin
      miscompares++; $display("FAIL b2b_ack: got %b want 1", bus.issue_ack_out);
    end
    tick();
    idle();
    vectors++;
    if (bus.request_flatted_out[1*W +: W] !== 64'h7 || bus.request_critical_flatted_out !== 3'b010
        || bus.request_valid_flatted_out !== 3'b010) begin
      miscompares++; $display("FAIL b2b_head: got %h c=%b v=%b want 7 010 010", bus.request_flatted_out[1*W +: W], bus.request_critical_flatted_out, bus.request_valid_flatted_out);
    end
    send(2'd1, 64'h8, 1'b0);
    tick();
    send(2'd1, 64'h9, 1'b0);
    #1;
    vectors++;
    if (bus.issue_ack_out !== 1'b0) begin
      miscompares++; $display("FAIL b2b_count: got ack %b want 0 (port 1 should hold 2)", bus.issue_ack_out);
    end
    idle();
    bus.issue_ack_flatted_in = 3'b010;
    tick();
    vectors++;
    if (bus.request_flatted_out[1*W +: W] !== 64'h8) begin
      miscompares++; $display("FAIL b2b_order: got %h want 8", bus.request_flatted_out[1*W +: W]);
    end
    tick();
    idle();
  endtask

  task automatic test_drop_and_async_reset();
    send(2'd3, 64'hBAD, 1'b0);
    #1;
    vectors++;
    if (bus.issue_ack_out !== 1'b1) begin
      miscompares++; $display("FAIL drop_ack0: got %b want 1", bus.issue_ack_out);
    end
    tick();
    vectors++;
    if (bus.issue_ack_out !== 1'b1) begin
      miscompares++; $display("FAIL drop_ack1: got %b want 1", bus.issue_ack_out);
    end
    tick();
    idle();
    vectors++;
    if (bus.drop_count_out !== 16'd2 || bus.request_valid_flatted_out !== 3'b000) begin
      miscompares++; $display("FAIL drop_count: got %0d v=%b want 2 000", bus.drop_count_out, bus.request_valid_flatted_out);
    end
    send(2'd0, 64'hC0, 1'b1);
    tick();
    send(2'd2, 64'hC1, 1'b0);
    #2;
    reset_in = 1'b1;
    #1;
    vectors++;
    if (bus.request_valid_flatted_out !== 3'b000 || bus.request_flatted_out !== '0
        || bus.request_critical_flatted_out !== 3'b000 || bus.drop_count_out !== 16'd0
        || bus.issue_ack_out !== 1'b0) begin
      miscompares++; $display("FAIL async_reset: got v=%b c=%b drop=%0d ack=%b want all zero", bus.request_valid_flatted_out, bus.request_critical_flatted_out, bus.drop_count_out, bus.issue_ack_out);
    end
    @(negedge clk_in);
    reset_in = 1'b0;
    idle();
    tick();
  endtask

`ifdef REQUEST_DISTRIBUTOR_BROADCAST_EN
  task automatic test_broadcast();
    send(2'd3, 64'hBEEF, 1'b0);
    bus.request_broadcast_in = 1'b1;
    #1;
    vectors++;
    if (bus.issue_ack_out !== 1'b1) begin
      miscompares++; $display("FAIL bc_ack: got %b want 1", bus.issue_ack_out);
    end
    tick();
    idle();
    vectors++;
    if (bus.request_valid_flatted_out !== 3'b111 || bus.drop_count_out !== 16'd0) begin
      miscompares++; $display("FAIL bc_valid: got v=%b drop=%0d want 111 0", bus.request_valid_flatted_out, bus.drop_count_out);
    end
    for (int p = 0; p < N; p++) begin
      vectors++;
      if (bus.request_flatted_out[p*W +: W] !== 64'hBEEF) begin
        miscompares++; $display("FAIL bc_head%0d: got %h want beef", p, bus.request_flatted_out[p*W +: W]);
      end
    end
    bus.issue_ack_flatted_in = 3'b011;
    send(2'd2, 64'h1, 1'b0);
    tick();
    idle();
    send(2'd0, 64'hF00D, 1'b0);
    bus.request_broadcast_in = 1'b1;
    #1;
    vectors++;
    if (bus.issue_ack_out !== 1'b0) begin
      miscompares++; $display("FAIL bc_full: got %b want 0", bus.issue_ack_out);
    end
    tick();
    idle();
    vectors++;
    if (bus.request_valid_flatted_out !== 3'b100) begin
      miscompares++; $display("FAIL bc_nowrite: got %b want 100", bus.request_valid_flatted_out);
    end
    reset_in = 1'b1;
    #1;
    reset_in = 1'b0;
    tick();
  endtask
`endif

  initial begin
    idle();
    #12;
    test_reset();
    test_unicast();
    test_full();
    test_pop_while_full();
    test_back_to_back();
    test_drop_and_async_reset();
`ifdef REQUEST_DISTRIBUTOR_BROADCAST_EN
    test_broadcast();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/request_distributor.md
Name: request_distributor

Overview:
- Inverse of the multi-input priority arbiter: accepts one request stream and routes each request to one of NUM_REQUEST downstream ports, selected by a destination index.
- Each port has its own circular FIFO, so a stalled consumer never blocks traffic to the other ports.
- Sits between a shared issue stage (for example, arbiter output or memory response path) and per-requester consumers.
- Uses the same valid/ack handshake as the arbiter.

Parameters:
- SINGLE_REQUEST_WIDTH_IN_BITS, 64, payload width of one request.
- NUM_REQUEST, 3, number of downstream ports.
- OUTPUT_QUEUE_SIZE, 2, entries per port FIFO; must be a power of 2 and at least 2.
- NUM_REQUEST_LOG2, $clog2(NUM_REQUEST), width of the destination index (minimum 1).

Ports:
- clk_in  input  1  clock.
- reset_in  input  1  reset, asynchronous, active-high.
- request_in  input  SINGLE_REQUEST_WIDTH_IN_BITS  incoming payload.
- request_dest_in  input  NUM_REQUEST_LOG2  destination port index.
- request_critical_in  input  1  critical tag, carried with the payload.
- request_valid_in  input  1  incoming request valid.
- issue_ack_out  output  1  request accepted this cycle (combinational).
- request_flatted_out  output  SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST  per-port head payload; port i at bits [i*W +: W].
- request_critical_flatted_out  output  NUM_REQUEST  per-port head critical tag.
- request_valid_flatted_out  output  NUM_REQUEST  per-port head valid.
- issue_ack_flatted_in  input  NUM_REQUEST  per-port consumer ack.
- drop_count_out  output  16  saturating count of requests dropped for an out-of-range destination.

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-high on reset_in. All state clears immediately when reset_in rises: every FIFO is emptied, pointers and counts go to 0, drop_count_out goes to 0.
- Outputs during and after reset: request_valid_flatted_out=0, request_flatted_out=0, request_critical_flatted_out=0, issue_ack_out=0.
- Per-port FIFO state: write pointer, read pointer, and an occupancy count of width $clog2(OUTPUT_QUEUE_SIZE)+1. Pointers wrap modulo OUTPUT_QUEUE_SIZE.
- full[i] = (count == OUTPUT_QUEUE_SIZE); empty[i] = (count == 0).
- Input acceptance, normal destination (request_dest_in < NUM_REQUEST): issue_ack_out = request_valid_in & ~full[dest].
- Input acceptance, out-of-range destination: issue_ack_out = request_valid_in. The request is discarded and drop_count_out increments, saturating at 16'hFFFF.
- Full check uses the current count only. A pop on the same port in the same cycle does not allow a push into a full queue.
- Push: on the clk_in edge where issue_ack_out=1, {request_critical_in, request_in} is written at wr_ptr[dest], and wr_ptr and count advance.
- Push latency: one cycle. A request accepted at edge N appears at the port head after edge N.
- Output side: request_valid_flatted_out[i] = ~empty[i]. The head payload and critical tag are driven from the read-pointer entry. Payload and critical are forced to 0 when the port is empty.
- Pop: on an edge where request_valid_flatted_out[i] & issue_ack_flatted_in[i], rd_ptr[i] and count[i] advance.
- An ack while the port is empty is ignored: no pointer movement, no underflow.
- Head stability: while valid is high and no ack has arrived, the head payload must stay stable (valid/ack contract).
- Simultaneous push and pop on the same port: both occur and count is unchanged. This is legal whenever the queue is not full. On an empty queue, the pushed entry becomes the head on the next cycle.
- Ordering: per-port FIFO order is preserved. There is no ordering guarantee across ports.
- Critical tag: carried through unchanged; it does not reorder entries inside the block.
- Reset mid-operation: entries in flight are lost; no partial outputs.

Optional Feature:
- Macro: REQUEST_DISTRIBUTOR_BROADCAST_EN.
- When defined, the block adds input port request_broadcast_in (1 bit).
- When request_broadcast_in=1, request_dest_in is ignored. issue_ack_out = request_valid_in & (no port full). On acceptance the request is pushed into every port in the same cycle.
- Broadcast requests never increment drop_count_out.
- When undefined, the port does not exist and all requests are unicast as described above.

Test Plan:
- Reset, then request_valid_in=1, dest=1, payload 64'hA5 -> issue_ack_out=1; next cycle valid_out=3'b010, port1 payload=64'hA5, critical=0.
- Fill port 0 with 64'h1 and 64'h2 (QUEUE_SIZE=2) with no acks, then present dest=0 -> issue_ack_out=0. Present dest=2 in the same cycle -> ack=1. Ack port 0 twice -> 64'h1 then 64'h2 popped, then valid_out[0]=0.
- Port 0 full; in one cycle assert issue_ack_flatted_in[0]=1 and push to dest=0 -> push rejected (ack_out=0), count drops to 1. Next cycle the push is accepted.
- Port 1 holds one entry; in one cycle push 64'h7 to dest=1 and ack port 1 -> count stays 1, head becomes 64'h7.
- dest=3 with NUM_REQUEST=3, valid for 2 cycles -> ack_out=1 both cycles, drop_count_out=2, no port valid. Assert reset_in asynchronously between clock edges -> outputs and drop_count_out are 0 before the next edge.
- With BROADCAST_EN, broadcast 64'hBEEF into empty queues -> valid_out=3'b111, all heads 64'hBEEF. With port 2 full -> ack_out=0 and no port written.
